// File: rtl/fetch_bpred.sv
// Fetch stage with PC register, F/D pipeline register and a direct-mapped BTB
// holding 2-bit saturating direction counters; redirects on Execute mispredicts.
module fetch_bpred #(
    parameter int              XLEN        = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic [31:0]     InstrF,
    input  logic            ResolveE,
    input  logic            TakenE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] TargetE,
    input  logic            PredTakenE,
    input  logic [XLEN-1:0] PredTargetE,
    output logic [XLEN-1:0] PCF,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            PredTakenD,
    output logic [XLEN-1:0] PredTargetD,
    output logic            MispredictE
);

    localparam int              IDXW = $clog2(BTB_ENTRIES);
    localparam int              TAGW = XLEN - IDXW - 2;
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    logic            r_valid  [BTB_ENTRIES];
    logic [TAGW-1:0] r_tag    [BTB_ENTRIES];
    logic [XLEN-1:0] r_target [BTB_ENTRIES];
    logic [1:0]      r_ctr    [BTB_ENTRIES];

    logic [XLEN-1:0] r_pcf;
    logic [31:0]     r_instr_d;
    logic [XLEN-1:0] r_pc_d;
    logic [XLEN-1:0] r_pcplus4_d;
    logic            r_pred_taken_d;
    logic [XLEN-1:0] r_pred_target_d;

    logic [IDXW-1:0] w_idx_f;
    logic [TAGW-1:0] w_tag_f;
    logic            w_hit_f;
    logic            w_pred_taken_f;
    logic [XLEN-1:0] w_pred_target_f;
    logic [XLEN-1:0] w_pcplus4_f;
    logic [IDXW-1:0] w_idx_e;
    logic [TAGW-1:0] w_tag_e;
    logic            w_hit_e;
    logic            w_mispredict;

    // Lookup reads the array before any same-cycle write lands.
    assign w_idx_f         = r_pcf[IDXW+1:2];
    assign w_tag_f         = r_pcf[XLEN-1:IDXW+2];
    assign w_hit_f         = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
    assign w_pred_taken_f  = w_hit_f && r_ctr[w_idx_f][1];
    assign w_pred_target_f = r_target[w_idx_f];
    assign w_pcplus4_f     = r_pcf + FOUR;

    assign w_idx_e = PCE[IDXW+1:2];
    assign w_tag_e = PCE[XLEN-1:IDXW+2];
    assign w_hit_e = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);

    assign w_mispredict = ResolveE &&
                          ((TakenE != PredTakenE) || (TakenE && (TargetE != PredTargetE)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'b00;
            end
        end else if (ResolveE) begin
            if (TakenE) begin
                if (w_hit_e) begin
                    r_ctr[w_idx_e] <= (r_ctr[w_idx_e] == 2'b11) ? 2'b11 : r_ctr[w_idx_e] + 2'd1;
                end else begin
                    r_valid[w_idx_e] <= 1'b1;
                    r_ctr[w_idx_e]   <= 2'b10;
                end
            end else if (w_hit_e) begin
                r_ctr[w_idx_e] <= (r_ctr[w_idx_e] == 2'b00) ? 2'b00 : r_ctr[w_idx_e] - 2'd1;
            end
        end
    end

    // Tag and target are meaningless while valid is low, so they carry no reset.
    always_ff @(posedge clk) begin
        if (ResolveE && TakenE) begin
            r_tag[w_idx_e]    <= w_tag_e;
            r_target[w_idx_e] <= TargetE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcf <= RESET_PC;
        end else if (w_mispredict) begin
            r_pcf <= TakenE ? TargetE : (PCE + FOUR);
        end else if (!StallF) begin
            r_pcf <= w_pred_taken_f ? w_pred_target_f : w_pcplus4_f;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr_d       <= '0;
            r_pc_d          <= '0;
            r_pcplus4_d     <= '0;
            r_pred_taken_d  <= 1'b0;
            r_pred_target_d <= '0;
        end else if (FlushD || w_mispredict) begin
            r_instr_d       <= '0;
            r_pc_d          <= '0;
            r_pcplus4_d     <= '0;
            r_pred_taken_d  <= 1'b0;
            r_pred_target_d <= '0;
        end else if (!StallD) begin
            r_instr_d       <= InstrF;
            r_pc_d          <= r_pcf;
            r_pcplus4_d     <= w_pcplus4_f;
            r_pred_taken_d  <= w_pred_taken_f;
            r_pred_target_d <= w_pred_target_f;
        end
    end

    assign PCF         = r_pcf;
    assign InstrD      = r_instr_d;
    assign PCD         = r_pc_d;
    assign PCPlus4D    = r_pcplus4_d;
    assign PredTakenD  = r_pred_taken_d;
    assign PredTargetD = r_pred_target_d;
    assign MispredictE = w_mispredict;

endmodule

// File: tb/tb_fetch_bpred.sv
// Scoreboard bench for fetch_bpred: a per-entry BTB model predicts every
// cycle's outputs, a negedge monitor pops and compares them.
module tb_fetch_bpred;

    localparam int          N       = 4;
    localparam logic [31:0] RST_PC  = 32'h100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0;
    logic [31:0] InstrF = '0;
    logic        ResolveE = 1'b0, TakenE = 1'b0, PredTakenE = 1'b0;
    logic [31:0] PCE = '0, TargetE = '0, PredTargetE = '0;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D, PredTargetD;
    logic        PredTakenD, MispredictE;

    fetch_bpred #(.XLEN(32), .BTB_ENTRIES(N), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .InstrF(InstrF), .ResolveE(ResolveE), .TakenE(TakenE), .PCE(PCE),
        .TargetE(TargetE), .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
        .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .PredTakenD(PredTakenD), .PredTargetD(PredTargetD), .MispredictE(MispredictE)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pcf;
        logic        mis;
        logic [31:0] instrd;
        logic [31:0] pcd;
        logic [31:0] pcp4d;
        logic        ptkd;
        logic [31:0] ptgd;
        logic        ptg_known;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference state: each BTB slot remembers the word address that owns it.
    logic [31:0] m_pcf, m_instrd, m_pcd, m_pcp4d, m_ptgd;
    logic        m_ptkd, m_ptgd_known;
    logic        m_valid [N];
    logic [29:0] m_owner [N];
    logic [31:0] m_target[N];
    int          m_ctr   [N];
    logic        m_known [N];

    task automatic model_reset();
        m_pcf = RST_PC; m_instrd = 0; m_pcd = 0; m_pcp4d = 0;
        m_ptkd = 0; m_ptgd = 0; m_ptgd_known = 1;
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_ctr[i] = 0; m_known[i] = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("PCF", PCF, e.pcf);
            chk("MispredictE", {31'b0, MispredictE}, {31'b0, e.mis});
            chk("InstrD", InstrD, e.instrd);
            chk("PCD", PCD, e.pcd);
            chk("PCPlus4D", PCPlus4D, e.pcp4d);
            chk("PredTakenD", {31'b0, PredTakenD}, {31'b0, e.ptkd});
            if (e.ptg_known) chk("PredTargetD", PredTargetD, e.ptgd);
        end
    end

    task automatic step(input logic rst, input logic sf, input logic sd, input logic fd,
                        input logic res, input logic tk, input logic [31:0] pce,
                        input logic [31:0] tgt, input logic ptke, input logic [31:0] ptge);
        exp_t        e;
        logic        mis, hit, ptk, pk, hit_e;
        logic [31:0] ptg, instr;
        int          idx, ide;
        @(posedge clk);
        #1;
        instr = $urandom;
        reset = rst; StallF = sf; StallD = sd; FlushD = fd; InstrF = instr;
        ResolveE = res; TakenE = tk; PCE = pce; TargetE = tgt;
        PredTakenE = ptke; PredTargetE = ptge;
        if (rst) model_reset();
        mis = res && ((tk != ptke) || (tk && (tgt != ptge)));
        e = '{pcf: m_pcf, mis: mis, instrd: m_instrd, pcd: m_pcd, pcp4d: m_pcp4d,
              ptkd: m_ptkd, ptgd: m_ptgd, ptg_known: m_ptgd_known};
        exp_q.push_back(e);
        if (!rst) begin
            idx = int'((m_pcf >> 2) % N);
            hit = m_valid[idx] && (m_owner[idx] == m_pcf[31:2]);
            ptk = hit && (m_ctr[idx] >= 2);
            ptg = m_target[idx];
            pk  = m_known[idx];
            if (fd || mis) begin
                m_instrd = 0; m_pcd = 0; m_pcp4d = 0; m_ptkd = 0; m_ptgd = 0; m_ptgd_known = 1;
            end else if (!sd) begin
                m_instrd = instr; m_pcd = m_pcf; m_pcp4d = m_pcf + 4;
                m_ptkd = ptk; m_ptgd = ptg; m_ptgd_known = pk;
            end
            if (mis)      m_pcf = tk ? tgt : pce + 4;
            else if (!sf) m_pcf = ptk ? ptg : m_pcf + 4;
            if (res) begin
                ide   = int'((pce >> 2) % N);
                hit_e = m_valid[ide] && (m_owner[ide] == pce[31:2]);
                if (tk) begin
                    m_target[ide] = tgt; m_known[ide] = 1;
                    if (hit_e) m_ctr[ide] = (m_ctr[ide] == 3) ? 3 : m_ctr[ide] + 1;
                    else begin
                        m_valid[ide] = 1; m_owner[ide] = pce[31:2]; m_ctr[ide] = 2;
                    end
                end else if (hit_e) begin
                    m_ctr[ide] = (m_ctr[ide] == 0) ? 0 : m_ctr[ide] - 1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic resolve(input logic tk, input logic [31:0] pce, input logic [31:0] tgt,
                           input logic ptke, input logic [31:0] ptge);
        step(0, 0, 0, 0, 1, tk, pce, tgt, ptke, ptge);
    endtask

    // A not-taken resolve that was predicted taken redirects fetch to pce+4.
    task automatic goto_pc(input logic [31:0] a);
        resolve(0, a - 32'd4, 32'h0, 1, 32'h0);
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 7))
            0: return 32'h10;
            1: return 32'h20;
            2: return 32'h30;
            3: return 32'h200;
            4: return 32'h204;
            5: return 32'h100;
            6: return 32'h108;
            default: return 32'hFFFF_FFFC;
        endcase
    endfunction

    initial begin
        model_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(4);
        // Allocate 0x200 -> 0x80, then fetch 0x200 and see the taken prediction.
        resolve(1, 32'h200, 32'h80, 0, 32'h0);
        idle(2);
        goto_pc(32'h200);
        idle(3);
        // Saturate up, then walk the counter down through the mispredicts.
        resolve(1, 32'h200, 32'h80, 1, 32'h80);
        resolve(1, 32'h200, 32'h80, 1, 32'h80);
        resolve(0, 32'h200, 32'h0, 1, 32'h80);
        goto_pc(32'h200);
        idle(2);
        resolve(0, 32'h200, 32'h0, 1, 32'h80);
        goto_pc(32'h200);
        idle(2);
        // Indirect target change on a hit.
        resolve(1, 32'h200, 32'h90, 1, 32'h80);
        goto_pc(32'h200);
        idle(3);
        // Not-taken predicted not-taken with a junk target is not a mispredict.
        resolve(0, 32'h204, 32'h0, 0, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 1, 1, 32'h30, 32'h44, 0, 32'h0);
        idle(2);
        // Aliasing at index 0 of a four-entry table.
        resolve(1, 32'h10, 32'h40, 0, 32'h0);
        resolve(1, 32'h20, 32'h60, 0, 32'h0);
        goto_pc(32'h10);
        idle(2);
        goto_pc(32'h20);
        idle(2);
        step(1, 0, 0, 0, 1, 1, 32'h20, 32'h70, 0, 32'h0);
        idle(2);
        goto_pc(32'h20);
        idle(2);
        goto_pc(32'hFFFF_FFFC);
        idle(2);
        resolve(0, 32'hFFFF_FFFC, 32'h0, 1, 32'h0);
        idle(2);
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] tgt;
            tgt = pick_addr();
            step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), pick_addr(), tgt,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? tgt : pick_addr());
        end
        idle(2);
        @(posedge clk);
        @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
